// File: rtl/lcd_sequencer_pkg.sv
// Shared definitions for the LCD sequencer: command bytes, FSM encodings, init ROM.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package lcd_sequencer_pkg;

  // HD44780 command bytes
  localparam logic [7:0] LCD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] LCD_CLEAR    = 8'h01;  // clear display, needs long settle
  localparam logic [7:0] LCD_ENTRY    = 8'h06;  // entry mode, increment
  localparam logic [7:0] LCD_LINE1    = 8'h80;  // DDRAM address line 1, column 0

  // Init ROM geometry; the clear command sits at INIT_CLR_IDX
  localparam int         INIT_ROM_LEN = 4;
  localparam logic [1:0] INIT_CLR_IDX = 2'd2;
  localparam logic [1:0] INIT_LAST    = 2'(INIT_ROM_LEN - 1);

  // Top FSM states
  localparam logic [2:0] S_PWR_WAIT = 3'd0;
  localparam logic [2:0] S_INIT     = 3'd1;
  localparam logic [2:0] S_CLR_WAIT = 3'd2;
  localparam logic [2:0] S_IDLE     = 3'd3;
  localparam logic [2:0] S_WR_ADDR  = 3'd4;
  localparam logic [2:0] S_WR_HI    = 3'd5;
  localparam logic [2:0] S_WR_LO    = 3'd6;

  // Transfer handshake states
  localparam logic [1:0] X_IDLE = 2'd0;
  localparam logic [1:0] X_REQ  = 2'd1;
  localparam logic [1:0] X_GAP  = 2'd2;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_FUNC_SET;
      2'd1:    return LCD_DISP_ON;
      2'd2:    return LCD_CLEAR;
      default: return LCD_ENTRY;
    endcase
  endfunction

  // Nibble to uppercase ASCII hex digit
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/lcd_sequencer_xfer.sv
// Single LCD transfer: latch data/RS, raise Start until Done, one gap cycle, then a done pulse.
// Latency: 3 cycles minimum from i_start to o_xfer_done; unbounded while i_done stays low.
// Backpressure: i_start is only honoured in X_IDLE; callers must wait for o_xfer_done.
module lcd_xfer
  import lcd_sequencer_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_data,
  input  logic       i_rs,
  input  logic       i_done,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_start,
  output logic       o_xfer_done
);

  logic [1:0] r_state;
  logic [7:0] r_data;
  logic       r_rs;
  logic       r_start;
  logic       r_done;

  // Handshake FSM; data/RS are latched at acceptance so they stay stable while Start is high
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= X_IDLE;
      r_data  <= 8'h00;
      r_rs    <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        X_IDLE: if (i_start) begin
          r_data  <= i_data;
          r_rs    <= i_rs;
          r_start <= 1'b1;
          r_state <= X_REQ;
        end
        X_REQ: if (i_done) begin
          r_start <= 1'b0;
          r_state <= X_GAP;
        end
        X_GAP: begin
          r_state <= X_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= X_IDLE;
      endcase
    end
  end

  assign o_lcd_data  = r_data;
  assign o_lcd_rs    = r_rs;
  assign o_lcd_start = r_start;
  assign o_xfer_done = r_done;

endmodule

// File: rtl/lcd_sequencer.sv
// Powers up and initialises an HD44780 via the lcd controller, then shows a byte as two hex chars.
// Latency: iUpdate in IDLE -> oLCD_Start on the next edge; an update is three transfers.
// Backpressure: requests outside IDLE collapse into one pending flag; value sampled at acceptance.
module lcd_sequencer
  import lcd_sequencer_pkg::*;
#(
  parameter int INIT_WAIT_CYC = 50000,
  parameter int CLR_WAIT_CYC  = 100000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [7:0] iValue,
  input  logic       iUpdate,
  output logic       oReady,
  output logic       oBusy,
  output logic [7:0] oLCD_DATA,
  output logic       oLCD_RS,
  output logic       oLCD_Start,
  input  logic       iLCD_Done
);

  // A zero wait is treated as a single cycle so the compare value never underflows
  localparam int INIT_EFF = (INIT_WAIT_CYC < 1) ? 1 : INIT_WAIT_CYC;
  localparam int CLR_EFF  = (CLR_WAIT_CYC < 1) ? 1 : CLR_WAIT_CYC;
  localparam int MAX_EFF  = (INIT_EFF > CLR_EFF) ? INIT_EFF : CLR_EFF;
  localparam int CNT_W    = $clog2(MAX_EFF + 1);
  localparam logic [CNT_W-1:0] INIT_CNT_LAST = CNT_W'(INIT_EFF - 1);
  localparam logic [CNT_W-1:0] CLR_CNT_LAST  = CNT_W'(CLR_EFF - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic             r_pend;
  logic [7:0]       r_val;
  logic             r_issued;

  logic             w_take;
  logic             w_xfer_start;
  logic [7:0]       w_data;
  logic             w_rs;
  logic             w_xfer_done;

  assign w_take = (r_state == S_IDLE) && (r_pend || iUpdate);

  // Select the byte for the current step; each step launches exactly one transfer
  always_comb begin
    w_data       = 8'h00;
    w_rs         = 1'b0;
    w_xfer_start = 1'b0;
    case (r_state)
      S_INIT: begin
        w_data       = init_rom(r_idx);
        w_xfer_start = !r_issued;
      end
      S_IDLE: begin
        w_data       = LCD_LINE1;
        w_xfer_start = w_take;
      end
      S_WR_ADDR: begin
        w_data       = LCD_LINE1;
        w_xfer_start = !r_issued;
      end
      S_WR_HI: begin
        w_data       = hex_ascii(r_val[7:4]);
        w_rs         = 1'b1;
        w_xfer_start = !r_issued;
      end
      S_WR_LO: begin
        w_data       = hex_ascii(r_val[3:0]);
        w_rs         = 1'b1;
        w_xfer_start = !r_issued;
      end
      default: ;
    endcase
  end

  // Sequencing FSM: power-up wait, init ROM with post-clear settle, then display writes
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state  <= S_PWR_WAIT;
      r_cnt    <= '0;
      r_idx    <= 2'd0;
      r_pend   <= 1'b0;
      r_val    <= 8'h00;
      r_issued <= 1'b0;
    end else begin
      if (iUpdate && (r_state != S_IDLE)) r_pend <= 1'b1;
      if (w_xfer_start) r_issued <= 1'b1;
      case (r_state)
        S_PWR_WAIT: begin
          if (r_cnt == INIT_CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= S_INIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_INIT: if (w_xfer_done) begin
          r_issued <= 1'b0;
          if (r_idx == INIT_CLR_IDX) begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_CLR_WAIT;
          end else if (r_idx == INIT_LAST) begin
            r_idx   <= 2'd0;
            r_state <= S_IDLE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_CLR_WAIT: begin
          if (r_cnt == CLR_CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= S_INIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_IDLE: if (w_take) begin
          r_val   <= iValue;
          r_pend  <= 1'b0;
          r_state <= S_WR_ADDR;
        end
        S_WR_ADDR: if (w_xfer_done) begin
          r_issued <= 1'b0;
          r_state  <= S_WR_HI;
        end
        S_WR_HI: if (w_xfer_done) begin
          r_issued <= 1'b0;
          r_state  <= S_WR_LO;
        end
        S_WR_LO: if (w_xfer_done) begin
          r_issued <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_PWR_WAIT;
      endcase
    end
  end

  lcd_xfer u_xfer (
    .i_clk       (iCLK),
    .i_rst       (iRST),
    .i_start     (w_xfer_start),
    .i_data      (w_data),
    .i_rs        (w_rs),
    .i_done      (iLCD_Done),
    .o_lcd_data  (oLCD_DATA),
    .o_lcd_rs    (oLCD_RS),
    .o_lcd_start (oLCD_Start),
    .o_xfer_done (w_xfer_done)
  );

  assign oBusy  = (r_state != S_IDLE);
  assign oReady = (r_state == S_IDLE) && !r_pend;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Scoreboarded bench for lcd_sequencer with a simple lcd controller model (Done 5 cycles after Start).
// Latency: n/a.
// Backpressure: model answers every transfer; all waits are cycle-bounded.
module tb_lcd_sequencer;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic [7:0] iValue = 8'h00;
  logic       iUpdate = 1'b0;
  logic       oReady, oBusy;
  logic [7:0] oLCD_DATA;
  logic       oLCD_RS, oLCD_Start;
  logic       iLCD_Done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] sb[$];

  lcd_sequencer #(.INIT_WAIT_CYC(4), .CLR_WAIT_CYC(8)) dut (
    .iCLK(iCLK), .iRST(iRST), .iValue(iValue), .iUpdate(iUpdate),
    .oReady(oReady), .oBusy(oBusy), .oLCD_DATA(oLCD_DATA), .oLCD_RS(oLCD_RS),
    .oLCD_Start(oLCD_Start), .iLCD_Done(iLCD_Done)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] asc(input logic [3:0] n);
    logic [7:0] base;
    base = (n > 4'd9) ? 8'd65 : 8'd48;  // 'A' or '0'
    return (n > 4'd9) ? base + 8'(n - 4'd10) : base + 8'(n);
  endfunction

  task automatic push_init();
    sb.push_back({1'b0, 8'h38});
    sb.push_back({1'b0, 8'h0C});
    sb.push_back({1'b0, 8'h01});
    sb.push_back({1'b0, 8'h06});
  endtask

  task automatic push_update(input logic [7:0] v);
    sb.push_back({1'b0, 8'h80});
    sb.push_back({1'b1, asc(v[7:4])});
    sb.push_back({1'b1, asc(v[3:0])});
  endtask

  // lcd controller model: Done high for one cycle, 5 cycles after Start rises
  int  m_cnt = 0;
  logic m_prev = 1'b0;
  initial begin
    forever begin
      @(posedge iCLK);
      #1;
      iLCD_Done = 1'b0;
      if (iRST) m_cnt = 0;
      else if (oLCD_Start && !m_prev) m_cnt = 5;
      else if (m_cnt != 0) begin
        m_cnt--;
        if (m_cnt == 0) iLCD_Done = 1'b1;
      end
      m_prev = oLCD_Start;
    end
  end

  // Monitor: pop expected transfer on each Start rise, check stability while Start is high
  logic       mon_prev = 1'b0;
  int         mon_gap  = 0;
  logic [8:0] mon_last = '0;
  logic [8:0] mon_cur  = '0;
  logic [8:0] mon_exp;
  initial begin
    forever begin
      @(negedge iCLK);
      if (iRST) begin
        mon_prev = 1'b0;
        mon_gap  = 0;
        mon_last = '0;
      end else begin
        if (oLCD_Start && !mon_prev) begin
          mon_cur = {oLCD_RS, oLCD_DATA};
          if (mon_last == 9'h001) chk("clr_gap_ge8", 32'(mon_gap >= 8), 1);
          if (sb.size() == 0) chk("unexpected_xfer", 0, 1);
          else begin
            mon_exp = sb.pop_front();
            chk("xfer_rs_data", 32'(mon_cur), 32'(mon_exp));
          end
          mon_last = mon_cur;
        end else if (oLCD_Start) begin
          chk("stable_rs_data", 32'({oLCD_RS, oLCD_DATA}), 32'(mon_cur));
        end
        if (oLCD_Start) mon_gap = 0;
        else mon_gap++;
        mon_prev = oLCD_Start;
      end
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Reset, check reset values, release, check quiet power-up window; optional early request
  task automatic do_reset(input bit early_upd, input logic [7:0] v);
    iRST = 1'b1;
    iUpdate = 1'b0;
    sb.delete();
    repeat (2) tick();
    chk("rst_start", 32'(oLCD_Start), 0);
    chk("rst_data", 32'(oLCD_DATA), 0);
    chk("rst_rs", 32'(oLCD_RS), 0);
    chk("rst_busy", 32'(oBusy), 1);
    chk("rst_ready", 32'(oReady), 0);
    iRST = 1'b0;
    push_init();
    if (early_upd) push_update(v);
    tick();
    chk("post_rst_busy", 32'(oBusy), 1);
    chk("post_rst_ready", 32'(oReady), 0);
    chk("post_rst_start", 32'(oLCD_Start), 0);
    for (int i = 0; i < 3; i++) begin
      if (i == 0 && early_upd) begin
        iValue = v;
        iUpdate = 1'b1;
      end else iUpdate = 1'b0;
      tick();
      chk("pwr_wait_no_start", 32'(oLCD_Start), 0);
    end
    iUpdate = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n;
    n = 0;
    while (!(oReady && sb.size() == 0 && !oLCD_Start) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic send_update(input logic [7:0] v);
    push_update(v);
    iValue = v;
    iUpdate = 1'b1;
    tick();
    iUpdate = 1'b0;
    chk("upd_latency_start", 32'(oLCD_Start), 1);
  endtask

  initial begin
    int n;
    // 1: init sequence
    do_reset(1'b0, 8'h00);
    n = 0;
    while (!oReady && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("init_timeout", 0, 1);
    chk("init_all_cmds_before_ready", 32'(sb.size()), 0);
    chk("init_busy", 32'(oBusy), 0);
    tick();

    // 2: 0x3C
    send_update(8'h3C);
    wait_ready("upd_3c", 200);
    chk("after_3c_busy", 32'(oBusy), 0);
    chk("after_3c_ready", 32'(oReady), 1);

    // 3: 0xAF and 0x00
    send_update(8'hAF);
    wait_ready("upd_af", 200);
    send_update(8'h00);
    wait_ready("upd_00", 200);

    // 4: merged requests, latest value displayed
    send_update(8'h3C);
    for (int i = 0; i < 3; i++) begin
      iUpdate = 1'b1;
      tick();
      iUpdate = 1'b0;
      tick();
      tick();
    end
    chk("merge_still_busy", 32'(oBusy), 1);
    iValue = 8'h15;
    push_update(8'h15);
    wait_ready("merge", 300);
    repeat (30) tick();
    chk("merge_no_extra", 32'(sb.size()), 0);
    chk("merge_ready", 32'(oReady), 1);

    // 5: request during power-up wait
    do_reset(1'b1, 8'h7E);
    wait_ready("early", 400);
    repeat (30) tick();
    chk("early_ready", 32'(oReady), 1);

    // 6: reset mid WR_HI with a pending request
    send_update(8'h3C);
    iUpdate = 1'b1;
    tick();
    iUpdate = 1'b0;
    n = 0;
    while (!(oLCD_Start && oLCD_RS) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("wrhi_timeout", 0, 1);
    iRST = 1'b1;
    sb.delete();
    tick();
    chk("rst_mid_start_drop", 32'(oLCD_Start), 0);
    do_reset(1'b0, 8'h00);
    wait_ready("restart", 400);
    repeat (40) tick();
    chk("pending_lost", 32'(sb.size()), 0);
    chk("restart_ready", 32'(oReady), 1);
    chk("restart_idle_start", 32'(oLCD_Start), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
